// File: rtl/seq_arith_nb_addsub_if.sv
// Request/response val/rdy bundle for the chunked signed add/subtract unit.
// The master issues operands and accepts results; the slave is the arithmetic unit.
interface seq_arith_nb_addsub_if #(
  parameter int p_nbits = 16
) ();
  logic               in_val;
  logic               in_rdy;
  logic               in_op;
  logic               in_sat;
  logic [p_nbits-1:0] in0;
  logic [p_nbits-1:0] in1;
  logic               out_val;
  logic               out_rdy;
  logic [p_nbits-1:0] out;
  logic               out_ovfl;

  modport master (
    output in_val, in_op, in_sat, in0, in1, out_rdy,
    input  in_rdy, out_val, out, out_ovfl
  );

  modport slave (
    input  in_val, in_op, in_sat, in0, in1, out_rdy,
    output in_rdy, out_val, out, out_ovfl
  );
endinterface

// File: rtl/seq_arith_nb_addsub.sv
// Multi-cycle signed add/subtract, one p_nchunk_bits chunk per cycle, LS chunk first,
// with signed-overflow flag and optional saturation.
module seq_arith_nb_addsub #(
  parameter int p_nbits       = 16,
  parameter int p_nchunk_bits = 4
) (
  input  logic             clk,
  input  logic             reset,
  seq_arith_nb_addsub_if.slave io
);
  localparam int C  = p_nchunk_bits;
  localparam int N  = p_nbits / p_nchunk_bits;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [p_nbits-1:0] a_reg, a_next, b_reg, b_next;
  logic [p_nbits-1:0] res_reg, res_next, out_reg, out_next;
  logic               op_reg, op_next, sat_reg, sat_next;
  logic               carry_reg, carry_next, ovfl_reg, ovfl_next;
  logic [CW-1:0]      cnt_reg, cnt_next;

  logic [C-1:0]       a_chunk, b_chunk;
  logic [C:0]         sum;
  logic [p_nbits-1:0] sum_ext, wrapped, sat_val;
  logic               last, ovfl_now;

  // Operands shift right each cycle so the active chunk is always at bit 0;
  // the result fills from the top so chunk 0 lands at the bottom after N shifts.
  always_comb begin
    a_chunk = a_reg[C-1:0];
    b_chunk = op_reg ? ~b_reg[C-1:0] : b_reg[C-1:0];
    sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{C{1'b0}}, carry_reg};
    sum_ext = '0;
    sum_ext[C-1:0] = sum[C-1:0];
    wrapped = (res_reg >> C) | (sum_ext << (p_nbits - C));
    last    = (cnt_reg == CW'(N - 1));
    // carry into MSB is a^b^s at that bit; XOR with carry out gives overflow
    ovfl_now = a_chunk[C-1] ^ b_chunk[C-1] ^ sum[C-1] ^ sum[C];
    sat_val  = a_chunk[C-1] ? {1'b1, {(p_nbits-1){1'b0}}} : {1'b0, {(p_nbits-1){1'b1}}};
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    out_next   = out_reg;
    op_next    = op_reg;
    sat_next   = sat_reg;
    carry_next = carry_reg;
    ovfl_next  = ovfl_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (io.in_val) begin
          a_next     = io.in0;
          b_next     = io.in1;
          op_next    = io.in_op;
          sat_next   = io.in_sat;
          carry_next = io.in_op;
          res_next   = '0;
          cnt_next   = '0;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        a_next     = a_reg >> C;
        b_next     = b_reg >> C;
        carry_next = sum[C];
        res_next   = wrapped;
        cnt_next   = cnt_reg + CW'(1);
        if (last) begin
          out_next   = (sat_reg && ovfl_now) ? sat_val : wrapped;
          ovfl_next  = ovfl_now;
          cnt_next   = '0;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_rdy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      out_reg   <= '0;
      op_reg    <= 1'b0;
      sat_reg   <= 1'b0;
      carry_reg <= 1'b0;
      ovfl_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      out_reg   <= out_next;
      op_reg    <= op_next;
      sat_reg   <= sat_next;
      carry_reg <= carry_next;
      ovfl_reg  <= ovfl_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign io.in_rdy   = (state_reg == S_IDLE);
  assign io.out_val  = (state_reg == S_DONE);
  assign io.out      = out_reg;
  assign io.out_ovfl = ovfl_reg;
endmodule

// File: doc/seq_arith_nb_addsub.md
# seq_arith_nb_addsub

Multi-cycle, parametrised signed add/subtract unit with optional saturation and signed-overflow reporting. Operands are processed in fixed-size chunks, least-significant chunk first, one chunk per cycle through a shared chunk adder. Latency/area are traded against operand width. The unit sits behind a val/rdy request interface and a val/rdy response interface, so it drops into latency-insensitive datapaths wherever the combinational 8-bit subtractor is too narrow or lacks an add/saturate mode.

## Interface

Parameters:
- p_nbits, 16, operand/result width; must be ≥ 2 and a multiple of p_nchunk_bits.
- p_nchunk_bits, 4, bits processed per cycle; N = p_nbits / p_nchunk_bits chunks per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_val  input  1  request valid.
- in_rdy  output  1  request ready; high only in IDLE.
- in_op  input  1  0 = add (in0 + in1), 1 = subtract (in0 − in1).
- in_sat  input  1  1 = saturate result on signed overflow.
- in0  input  p_nbits  operand A, two's complement.
- in1  input  p_nbits  operand B, two's complement.
- out_val  output  1  response valid.
- out_rdy  input  1  response ready.
- out  output  p_nbits  result.
- out_ovfl  output  1  signed overflow occurred (reported regardless of in_sat).

## Operation

- FSM states: IDLE → CALC → DONE → IDLE.
- IDLE: in_rdy=1. On in_val && in_rdy, register in0, in1, in_op, in_sat. Clear the chunk counter. Set carry = in_op. Go to CALC.
- CALC: each cycle, compute chunk k = A[k] + (in_op ? ~B[k] : B[k]) + carry. Write it into result bits [k·C +: C] and update carry. After chunk N−1, go to DONE.
- Overflow = carry into MSB XOR carry out of MSB. Equivalently, the effective operand signs match and the result sign differs.
- Saturation applies when in_sat && overflow. The result is 0111…1 if A is non-negative, otherwise 1000…0. Otherwise the result is the wrapped modulo-2^p_nbits value.
- DONE: out_val=1. out and out_ovfl stay stable until out_val && out_rdy, then go to IDLE.
- in_rdy is 0 in CALC and DONE; at most one operation is in flight.
- in0/in1/in_op/in_sat are sampled only at acceptance. Later changes have no effect.
- out/out_ovfl keep their last value outside DONE. They are only meaningful while out_val=1.

## Timing

- Reset values: state=IDLE, in_rdy=1, out_val=0, out=0, out_ovfl=0, chunk counter=0, carry=0.
- Latency: request accepted at edge t ⇒ out_val=1 in the cycle following edge t+N. Example: N=4 gives out_val visible 5 edges after the accepting edge counted inclusively.
- The response handshake at edge u ⇒ in_rdy=1 from the cycle after u. A new request can't be accepted in the same cycle as the response handshake.
- Throughput: one operation per N+2 cycles with out_rdy held high.
- Backpressure: out_rdy=0 holds DONE indefinitely. out/out_ovfl/out_val do not change.
- Reset in any state, including mid-CALC, discards the operation. All outputs take reset values in the following cycle, and no response is produced.
- N=1 (p_nbits == p_nchunk_bits): CALC lasts exactly one cycle.

## Test plan

- Default params. Add 0x002A + 0x000D, in_sat=0 → out=0x0037, out_ovfl=0. out_val rises exactly N=4 cycles after the CALC entry. in_rdy=0 throughout.
- Default params. Subtract 0x000D − 0x002A → out=0xFFE3 (−29), out_ovfl=0. Then subtract 0xFFFF − 0x0000 → 0xFFFF, ovfl=0.
- Default params. Subtract 0x8000 − 0x0001: with in_sat=0 → out=0x7FFF, ovfl=1. With in_sat=1 → out=0x8000, ovfl=1. Add 0x7FFF + 0x0001: with in_sat=1 → out=0x7FFF, ovfl=1.
- Backpressure. Hold out_rdy=0 for 3 cycles in DONE → out/out_ovfl stable, in_rdy=0. Toggling in0/in1/in_val meanwhile has no effect. Then out_rdy=1 → out_val=0 and in_rdy=1 next cycle. Issue back-to-back requests → each is accepted N+2 cycles apart.
- Reset mid-operation. Assert reset for one cycle in the 2nd CALC cycle → next cycle in_rdy=1, out_val=0, out=0. A fresh add 1 + 1 then yields 0x0002.
- p_nbits=8, p_nchunk_bits=8. Subtract 0x00 − 0x80 → out=0x80, ovfl=1, out_val one cycle after CALC. Then run 20 random operand/op/sat triples against a behavioural model.
